// File: rtl/md_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state encoding and iteration count.
package md_unit_pkg;

   localparam int MD_ITERS = 32;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Restoring-division datapath for md_unit: partial remainder, quotient shift
// register and the subtract/restore step, sequenced by the parent FSM.
module md_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // The dividend drains out of the quotient register's MSB as quotient bits enter its LSB.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor};

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
      end else if (step) begin
         if (diff[WIDTH]) begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end else begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Optional MD_UNIT_FAST_MUL_EN: single-cycle combinational multiply.
import md_unit_pkg::*;

module md_unit #(
   parameter int WIDTH = MD_ITERS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   md_state_e          state_q, state_d;
   logic               accept, mt_hi, mt_lo;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_mag, b_mag, rs_mag, rt_mag;
   logic               signed_op, rs_neg, rt_neg;
   logic               is_div, neg_res, neg_rem, div_zero;
   logic [2*WIDTH-1:0] acc, product, signed_prod;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

   assign signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV);
   assign rs_neg    = signed_op & rs_data[WIDTH-1];
   assign rt_neg    = signed_op & rt_data[WIDTH-1];
   assign rs_mag    = rs_neg ? -rs_data : rs_data;
   assign rt_mag    = rt_neg ? -rt_data : rt_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      mt_hi   = 1'b0;
      mt_lo   = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            if (op <= MD_OP_DIVU) begin
               accept  = 1'b1;
               state_d = S_CALC;
`ifdef MD_UNIT_FAST_MUL_EN
               if (op == MD_OP_MULT || op == MD_OP_MULTU) state_d = S_FIX;
`endif
            end else if (op == MD_OP_MTHI) begin
               mt_hi = 1'b1;
            end else if (op == MD_OP_MTLO) begin
               mt_lo = 1'b1;
            end
         end
         S_CALC:  if (cnt == LAST) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set, then shift right.
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         acc      <= '0;
         a_mag    <= '0;
         b_mag    <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
      end else if (accept) begin
         cnt      <= '0;
         acc      <= {{WIDTH{1'b0}}, rt_mag};
         a_mag    <= rs_mag;
         b_mag    <= rt_mag;
         is_div   <= op[1];
         neg_res  <= rs_neg ^ rt_neg;
         neg_rem  <= rs_neg;
         div_zero <= (rt_data == '0);
      end else if (state_q == S_CALC) begin
         cnt <= cnt + CNT_W'(1);
         acc <= {mul_sum, acc[WIDTH-1:1]};
      end
   end

   md_div_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .step      (state_q == S_CALC),
      .dividend  (rs_mag),
      .divisor   (b_mag),
      .quotient  (quo),
      .remainder (rem)
   );

`ifdef MD_UNIT_FAST_MUL_EN
   assign product = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
   assign product = acc;
`endif
   assign signed_prod = neg_res ? -product : product;

   // Remainder restored to the dividend's sign also yields hi = rs_data on divide-by-zero.
   always_comb begin
      res_hi = signed_prod[2*WIDTH-1:WIDTH];
      res_lo = signed_prod[WIDTH-1:0];
      if (is_div) begin
         res_hi = neg_rem ? -rem : rem;
         res_lo = div_zero ? '1 : (neg_res ? -quo : quo);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi   <= '0;
         lo   <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_d != S_IDLE);
         done <= (state_q == S_FIX);
         if (state_q == S_FIX) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (mt_hi) begin
            hi <= rs_data;
         end else if (mt_lo) begin
            lo <= rs_data;
         end
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: issued ops push expected HI/LO and completion
// cycle; a negedge monitor pops and compares whenever done is seen.
module tb_md_unit;
   import md_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] rs_data = '0;
   logic [W-1:0] rt_data = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   md_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           due;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         mon_e;
   int           n_cmp = 0;
   int           n_fail = 0;
   int           cyc = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the architectural rules.
   function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         MD_OP_MULT:  return 64'(sa * sb);
         MD_OP_MULTU: return {32'd0, a} * {32'd0, b};
         MD_OP_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int latency(input logic [2:0] o);
`ifdef MD_UNIT_FAST_MUL_EN
      if (o == MD_OP_MULT || o == MD_OP_MULTU) return 1;
`endif
      return 33;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return 32'd1;
         2: return '1;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 100));
         default: return $urandom();
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
         end else begin
            mon_e = sb_q.pop_front();
            check("result_hi", 64'(hi), 64'(mon_e.hi));
            check("result_lo", 64'(lo), 64'(mon_e.lo));
            check("done_cycle", 64'(cyc), 64'(mon_e.due));
            m_hi = mon_e.hi;
            m_lo = mon_e.lo;
         end
      end
   end

   // now=1 drives in the current cycle (caller already sits at a negedge).
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
      logic [63:0] r;
      exp_t e;
      if (!now) @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (o <= MD_OP_DIVU) begin
         r = ref_md(o, a, b);
         e.hi = r[63:32];
         e.lo = r[31:0];
         e.due = cyc + latency(o);
         sb_q.push_back(e);
      end else if (o == MD_OP_MTHI) begin
         m_hi = a;
      end else if (o == MD_OP_MTLO) begin
         m_lo = a;
      end
   endtask

   task automatic drain();
      int budget;
      budget = 100;
      while (sb_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      logic [2:0] ro;
      int budget;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);
      rst_n = 1'b1;

      // Directed cases; HI/LO must hold their old value during CALC
      issue(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check("busy_after_issue", 64'(busy), 64'(1));
      repeat (10) @(negedge clk);
      check("hold_hi_calc", 64'(hi), 64'd0);
      check("hold_lo_calc", 64'(lo), 64'd0);
      drain();
      check("busy_after_done", 64'(busy), 64'd0);
      issue(MD_OP_MULT, 32'hFFFF_FFF9, 32'd6, 0);          drain();
      issue(MD_OP_DIV, 32'hFFFF_FFEF, 32'd5, 0);           drain();
      issue(MD_OP_DIVU, 32'd100, 32'd0, 0);                drain();
      issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);   drain();
      issue(MD_OP_DIV, 32'hFFFF_FFF0, 32'd0, 0);           drain();

      // start while busy is ignored
      issue(MD_OP_DIVU, 32'd1000, 32'd7, 0);
      repeat (3) @(negedge clk);
      start = 1'b1; op = MD_OP_DIVU; rs_data = 32'd5; rt_data = 32'd1;
      @(negedge clk);
      start = 1'b0;
      check("busy_during_ignored", 64'(busy), 64'd1);
      drain();

      // MTHI / MTLO in IDLE
      issue(MD_OP_MTHI, 32'h1234, 32'd0, 0);
      check("mthi_hi", 64'(hi), 64'h1234);
      check("mthi_busy", 64'(busy), 64'd0);
      issue(MD_OP_MTLO, 32'hCAFE, 32'd0, 0);
      check("mtlo_lo", 64'(lo), 64'hCAFE);
      check("mtlo_hi_kept", 64'(hi), 64'h1234);

      // Reserved op leaves everything untouched
      issue(3'd6, 32'hDEAD_BEEF, 32'd1, 0);
      issue(3'd7, 32'hDEAD_BEEF, 32'd1, 0);
      repeat (3) @(negedge clk);
      check("reserved_hi", 64'(hi), 64'(m_hi));
      check("reserved_lo", 64'(lo), 64'(m_lo));
      check("reserved_busy", 64'(busy), 64'd0);

      // Back-to-back: issue in the done cycle
      issue(MD_OP_MULTU, 32'd12345, 32'd678, 0);
      budget = 100;
      do begin
         @(negedge clk);
         budget--;
      end while (!done && budget > 0);
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL b2b_wait_done: got done=0, expected 1 within budget");
      end
      issue(MD_OP_MULTU, 32'hABCD_0123, 32'h0000_FFFF, 1);
      check("b2b_accepted", 64'(busy), 64'(latency(MD_OP_MULTU) > 1));
      drain();

      issue(MD_OP_MULTU, 32'd3, 32'd4, 0);
`ifdef MD_UNIT_FAST_MUL_EN
      @(posedge clk);
      #1;
      check("fast_lo_e1", 64'(lo), 64'd12);
      check("fast_busy_e1", 64'(busy), 64'd0);
`endif
      drain();

      // Randomized ops with corner operands
      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 3));
         issue(ro, pick(), pick(), 0);
         if (ro >= MD_OP_DIV) begin
            repeat (4) @(negedge clk);
            check("rand_hold_hi", 64'(hi), 64'(m_hi));
            check("rand_hold_lo", 64'(lo), 64'(m_lo));
         end
         drain();
      end

      // Reset mid-operation aborts immediately
      issue(MD_OP_MULT, 32'd77, 32'd99, 0);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      m_hi = '0;
      m_lo = '0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(MD_OP_MTLO, 32'h5, 32'd0, 0);
      check("post_abort_lo", 64'(lo), 64'h5);
      check("post_abort_hi", 64'(hi), 64'd0);
      repeat (40) @(negedge clk);
      check("post_abort_done", 64'(done), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the single-cycle CPU, sitting directly downstream of the register file. Consumes the two register read operands (RD1 as rs, RD2 as rt) for MULT/MULTU/DIV/DIVU, holds results in private HI/LO registers, and supplies them to the writeback mux for MFHI/MFLO. Asserts `busy` so the control unit stalls the PC while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: issue strobe for a `op` command; sampled on `clk` rising edge.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, ignored.
- `rs_data` input WIDTH: first operand, from register file RD1.
- `rt_data` input WIDTH: second operand, from register file RD2.
- `busy` output 1: operation in flight; CPU must stall.
- `done` output 1: one-cycle pulse when HI/LO receive a multiply/divide result.
- `hi` output WIDTH: HI register; high product or remainder.
- `lo` output WIDTH: LO register; low product or quotient.

## Operation
- States: IDLE, CALC, FIX. Reset puts the FSM in IDLE, clears `busy`, `done`, `hi`, `lo` and the iteration counter to 0.
- IDLE + `start` + op 0–3: latch operands. For signed ops, latch magnitudes plus result-sign flags. Load counter 0. Go to CALC.
- IDLE + `start` + op 4/5: `hi` (or `lo`) ← `rs_data` at that edge. Stay in IDLE. `busy` stays low.
- CALC, multiply: shift-add, one multiplier bit per cycle into a 2·WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC: counter increments each cycle. At count WIDTH−1, go to FIX.
- FIX: apply signs. Product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign. Write `hi`/`lo`, pulse `done`, return to IDLE.
- Divide by zero: no trap. Result is `lo` = all ones, `hi` = `rs_data` as latched. Total latency is unchanged.
- Signed overflow (−2^31 / −1): `lo` = 0x80000000, `hi` = 0.
- `start` while `busy`: ignored. No queueing.
- Reserved op values: ignored in every state.
- Asserting `rst_n` low mid-operation aborts the operation immediately. All state returns to reset values, and `hi`/`lo` read 0.

## Timing
- `start` sampled at edge E0 → `busy` high from just after E0.
- CALC occupies E1..E32. FIX is the E33 edge.
- `hi`/`lo` update at E33. `busy` falls at E33, and `done` is high for the cycle following E33.
- Total: 33 cycles from issue to result.
- `start` may be asserted again in the cycle `done` is high. The request is accepted at the next edge (back-to-back issue).
- `hi`/`lo` are registered outputs. They are stable throughout CALC and hold their previous values until FIX.
- `busy` is registered. It is low in the same cycle that MFHI/MFLO may read the new value.

## Configuration
- `MD_UNIT_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational `*` of the latched magnitudes.
  - The FSM goes IDLE → FIX → IDLE, so `hi`/`lo` update at E1 and `done` is high the following cycle. `busy` is high for exactly one cycle.
  - Divide is unchanged.
- Undefined: all four ops are iterative, with 33-cycle latency.

## Structure
- Shared package `md_unit_pkg`:
  - op encoding constants (`MD_OP_MULT` … `MD_OP_MTLO`);
  - FSM state encoding;
  - `MD_ITERS` = 32.
- One sub-module, `md_div_core`: the restoring-division datapath (partial remainder, quotient shift register, subtract/restore step), controlled by the parent FSM.
- The multiply datapath and sign fix-up stay in the top module.

## Test plan
- Reset mid-operation: MULT, then pull `rst_n` low at cycle 10 → `busy`=0, `hi`=`lo`=0 immediately; a subsequent MTLO 0x5 gives `lo`=0x5.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, single `done` pulse.
- MULT −7 × 6 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFD6.
- DIV −17 / 5 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFE (−2). DIVU 100 / 0 → `lo`=0xFFFFFFFF, `hi`=100.
- `start` DIVU while `busy` → ignored, first result intact. MTHI 0x1234 in IDLE → `hi`=0x1234 next cycle, `busy` never rises.
- Back-to-back: new MULTU issued in the `done` cycle → accepted, second result 33 cycles later. With `MD_UNIT_FAST_MUL_EN` defined: MULTU 3 × 4 → `lo`=12 at E1.
